// File: rtl/bit_packer_pkg.sv
// Shared width helpers and symbol mask for the variable-length bit packer.
package bit_packer_pkg;

  // Widest datapath the mask helper supports (OUT_W upper bound).
  localparam int unsigned MAX_W = 64;

  // Width of a length field able to hold 0..in_w.
  function automatic int unsigned len_w(input int unsigned in_w);
    return $clog2(in_w + 1);
  endfunction

  // Width of a fill counter holding 0..out_w-1.
  function automatic int unsigned cnt_w(input int unsigned out_w);
    return $clog2(out_w);
  endfunction

  // Ones in the low len bits, saturating at in_w bits; callers slice to IN_W.
  function automatic logic [MAX_W-1:0] len_mask(input int unsigned len,
                                                 input int unsigned in_w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      m[i] = (i < len) && (i < in_w);
    end
    return m;
  endfunction

endpackage

// File: rtl/bit_packer_fifo.sv
// Register FIFO with two ordered write ports (port 0 lands first) and one read port.
module bit_packer_fifo #(
  parameter int unsigned W     = 33,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we0,
  input  logic [W-1:0]     i_wd0,
  input  logic             i_we1,
  input  logic [W-1:0]     i_wd1,
  input  logic             i_re,
  output logic [W-1:0]     o_rd,
  output logic             o_empty,
  output logic [OCC_W-1:0] o_occ
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_pop;
  logic [PTR_W-1:0] w_wr_ptr1;

  // Pop only a valid head; port 1 follows port 0 when both write.
  always_comb begin
    w_pop     = i_re && (r_occ != '0);
    w_wr_ptr1 = r_wr_ptr + PTR_W'(i_we0);
  end

  // Storage, pointers and occupancy; occupancy moves by writes minus pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_we0) r_mem[r_wr_ptr]  <= i_wd0;
      if (i_we1) r_mem[w_wr_ptr1] <= i_wd1;
      r_wr_ptr <= r_wr_ptr + PTR_W'(i_we0) + PTR_W'(i_we1);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_occ    <= r_occ + OCC_W'(i_we0) + OCC_W'(i_we1) - OCC_W'(w_pop);
    end
  end

  assign o_rd    = r_mem[r_rd_ptr];
  assign o_empty = (r_occ == '0);
  assign o_occ   = r_occ;

endmodule

// File: rtl/bit_packer.sv
// Variable-length LSB-first bit packer with flush/zero-pad and a small output FIFO.
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int unsigned OUT_W = 32,
  parameter int unsigned IN_W  = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LEN_W = len_w(IN_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [LEN_W-1:0] i_len,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_last,
  output logic [2:0]       rest,
  output logic             err
);

  localparam int unsigned ACC_W  = 2 * OUT_W;
  localparam int unsigned CNT_W  = cnt_w(OUT_W);
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned WORD_W = OUT_W + 1;
  localparam int unsigned OCC_W  = $clog2(DEPTH + 1);

  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_rest;
  logic              r_err;

  logic              w_accept;
  logic              w_over;
  logic [LEN_W-1:0]  w_len_eff;
  logic [IN_W-1:0]   w_mask;
  logic [ACC_W-1:0]  w_acc_sum;
  logic [SUM_W-1:0]  w_sum;
  logic              w_full;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_we0;
  logic              w_we1;
  logic [WORD_W-1:0] w_wd0;
  logic [WORD_W-1:0] w_wd1;
  logic [WORD_W-1:0] w_head;
  logic              w_empty;
  logic [OCC_W-1:0]  w_occ;
  logic [OCC_W-1:0]  w_free;

  // Over-long symbols saturate at IN_W bits; the symbol is masked and placed at offset cnt.
  always_comb begin
    w_over    = (i_len > LEN_W'(IN_W));
    w_len_eff = w_over ? LEN_W'(IN_W) : i_len;
    w_mask    = IN_W'(len_mask(32'(w_len_eff), IN_W));
    w_acc_sum = r_acc | (ACC_W'(i_data & w_mask) << r_cnt);
    w_sum     = SUM_W'(r_cnt) + SUM_W'(w_len_eff);
    w_full    = (w_sum >= SUM_W'(OUT_W));
  end

  // Next accumulator state and the 0..2 words written by this accept.
  always_comb begin
    w_acc_nxt = r_acc;
    w_cnt_nxt = r_cnt;
    w_we0     = 1'b0;
    w_we1     = 1'b0;
    w_wd0     = '0;
    w_wd1     = '0;
    if (w_accept) begin
      w_acc_nxt = w_acc_sum;
      w_cnt_nxt = CNT_W'(w_sum);
      if (w_full) begin
        w_we0     = 1'b1;
        w_wd0     = {1'b0, w_acc_sum[OUT_W-1:0]};
        w_acc_nxt = w_acc_sum >> OUT_W;
        w_cnt_nxt = CNT_W'(w_sum - SUM_W'(OUT_W));
      end
      if (i_flush) begin
        if (w_cnt_nxt != '0) begin
          // Residual bits above cnt are already zero, so the low word is the padded tail.
          if (w_full) begin
            w_we1 = 1'b1;
            w_wd1 = {1'b1, w_acc_nxt[OUT_W-1:0]};
          end else begin
            w_we0 = 1'b1;
            w_wd0 = {1'b1, w_acc_nxt[OUT_W-1:0]};
          end
          w_acc_nxt = '0;
          w_cnt_nxt = '0;
        end else if (w_full) begin
          w_wd0[OUT_W] = 1'b1;
        end
      end
    end
  end

  // Accumulator, fill count, byte-alignment residue and sticky length error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_rest <= '0;
      r_err  <= 1'b0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_cnt  <= w_cnt_nxt;
      r_rest <= 3'd0 - w_cnt_nxt[2:0];
      r_err  <= r_err | (w_accept && w_over);
    end
  end

  bit_packer_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_we0   (w_we0),
    .i_wd0   (w_wd0),
    .i_we1   (w_we1),
    .i_wd1   (w_wd1),
    .i_re    (o_ready),
    .o_rd    (w_head),
    .o_empty (w_empty),
    .o_occ   (w_occ)
  );

  // Ready needs room for a worst-case two-word accept; depends only on registered occupancy.
  always_comb begin
    w_free   = OCC_W'(DEPTH) - w_occ;
    i_ready  = (w_free >= OCC_W'(2));
    w_accept = i_valid && i_ready;
  end

  assign o_valid = !w_empty;
  assign o_data  = w_head[OUT_W-1:0];
  assign o_last  = w_head[OUT_W];
  assign rest    = r_rest;
  assign err     = r_err;

endmodule

// File: tb/tb_bit_packer.sv
// Self-checking bench for bit_packer against a bit-queue reference model.
`timescale 1ns/1ps
module tb_bit_packer;

  localparam int unsigned OUT_W = 32;
  localparam int unsigned IN_W  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LEN_W = $clog2(IN_W + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_valid = 1'b0;
  logic             i_ready;
  logic [LEN_W-1:0] i_len = '0;
  logic [IN_W-1:0]  i_data = '0;
  logic             i_flush = 1'b0;
  logic             o_valid;
  logic             o_ready = 1'b0;
  logic [OUT_W-1:0] o_data;
  logic             o_last;
  logic [2:0]       rest;
  logic             err;

  bit               mbits[$];
  logic [OUT_W:0]   expq[$];
  logic [OUT_W:0]   gotq[$];
  bit               err_m = 1'b0;
  bit               auto_rdy = 1'b0;
  int               total = 0;
  int               bad = 0;

  bit_packer #(.OUT_W(OUT_W), .IN_W(IN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_len(i_len), .i_data(i_data), .i_flush(i_flush),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last),
    .rest(rest), .err(err)
  );

  always #5 clk = ~clk;

  // Record every word handed to the sink (popped on the following rising edge).
  always @(negedge clk) begin
    if (!rst && o_valid && o_ready) gotq.push_back({o_last, o_data});
  end

  // Reference: append symbol bits to a bit stream, cut whole words, pad and tag on flush.
  function automatic void model_push(input int len, input logic [IN_W-1:0] data, input bit flush);
    int unsigned    eff;
    int             n;
    bit             emitted;
    logic [OUT_W-1:0] w;
    logic [OUT_W:0]   t;
    eff = (len > int'(IN_W)) ? IN_W : len;
    emitted = 1'b0;
    if (len > int'(IN_W)) err_m = 1'b1;
    for (int unsigned i = 0; i < eff; i++) mbits.push_back(data[i]);
    while (mbits.size() >= int'(OUT_W)) begin
      for (int i = 0; i < int'(OUT_W); i++) w[i] = mbits.pop_front();
      expq.push_back({1'b0, w});
      emitted = 1'b1;
    end
    if (flush) begin
      if (mbits.size() > 0) begin
        w = '0;
        n = mbits.size();
        for (int i = 0; i < n; i++) w[i] = mbits.pop_front();
        expq.push_back({1'b1, w});
      end else if (emitted) begin
        t = expq.pop_back();
        t[OUT_W] = 1'b1;
        expq.push_back(t);
      end
    end
  endfunction

  function automatic logic [2:0] model_rest();
    return 3'((8 - (mbits.size() % 8)) % 8);
  endfunction

  // Present one symbol, wait (bounded) for acceptance, update the model.
  task automatic send(input int len, input logic [IN_W-1:0] data, input bit flush);
    int n;
    n = 0;
    i_valid = 1'b1;
    i_len   = LEN_W'(len);
    i_data  = data;
    i_flush = flush;
    @(negedge clk);
    while (!i_ready && n < 200) begin
      if (auto_rdy && n >= 2) o_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout i_ready=%0b after %0d cycles, required 1", i_ready, n);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    model_push(len, data, flush);
  endtask

  task automatic drain();
    o_ready = 1'b1;
    repeat (2 * DEPTH + 4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_o_valid got=%b exp=0", o_valid); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL rst_o_data got=%h exp=0", o_data); end
    total++; if (o_last !== 1'b0) begin bad++; $display("FAIL rst_o_last got=%b exp=0", o_last); end
    total++; if (rest !== 3'd0) begin bad++; $display("FAIL rst_rest got=%0d exp=0", rest); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL rst_i_ready got=%b exp=1", i_ready); end
  endtask

  task automatic test_nibbles();
    o_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(4, IN_W'(k), 1'b0);
      total++;
      if (rest !== model_rest()) begin bad++; $display("FAIL nib_rest%0d got=%0d exp=%0d", k, rest, model_rest()); end
    end
    drain();
    total++;
    if (gotq.size() != 1 || gotq[0] !== 33'h0_8765_4321) begin
      bad++; $display("FAIL nib_word n=%0d got=%h exp=087654321", gotq.size(), (gotq.size() > 0) ? gotq[0] : 'x);
    end
    total++;
    if (gotq.size() != expq.size()) begin bad++; $display("FAIL nib_count got=%0d exp=%0d", gotq.size(), expq.size()); end
    gotq.delete(); expq.delete();
  endtask

  task automatic test_mixed();
    send(24, 32'h00AB_CDEF, 1'b0);
    total++; if (rest !== 3'd0) begin bad++; $display("FAIL mix_rest24 got=%0d exp=0", rest); end
    send(16, 32'h0000_1234, 1'b0);
    total++; if (rest !== model_rest()) begin bad++; $display("FAIL mix_rest40 got=%0d exp=%0d", rest, model_rest()); end
    send(0, 32'hFFFF_FFFF, 1'b1);
    drain();
    total++;
    if (gotq.size() != expq.size()) begin bad++; $display("FAIL mix_count got=%0d exp=%0d", gotq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      total++;
      if (gotq[i] !== expq[i]) begin bad++; $display("FAIL mix_word%0d got=%h exp=%h", i, gotq[i], expq[i]); end
    end
    total++;
    if (gotq.size() < 1 || gotq[0] !== 33'h0_34AB_CDEF) begin bad++; $display("FAIL mix_first got=%h exp=034abcdef", (gotq.size() > 0) ? gotq[0] : 'x); end
    gotq.delete(); expq.delete();
  endtask

  task automatic test_flush();
    send(5, 32'hFFFF_FF1F, 1'b1);
    total++; if (rest !== 3'd0) begin bad++; $display("FAIL fl_rest got=%0d exp=0", rest); end
    send(0, 32'h0, 1'b1);
    drain();
    total++;
    if (gotq.size() != expq.size()) begin bad++; $display("FAIL fl_count got=%0d exp=%0d", gotq.size(), expq.size()); end
    total++;
    if (gotq.size() < 1 || gotq[0] !== 33'h1_0000_001F) begin bad++; $display("FAIL fl_word got=%h exp=10000001f", (gotq.size() > 0) ? gotq[0] : 'x); end
    gotq.delete(); expq.delete();
  endtask

  task automatic test_double_write();
    o_ready = 1'b0;
    send(16, 32'h0000_BEEF, 1'b0);
    send(32, 32'h1234_5678, 1'b1);
    drain();
    total++;
    if (gotq.size() != expq.size()) begin bad++; $display("FAIL dbl_count got=%0d exp=%0d", gotq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      total++;
      if (gotq[i] !== expq[i]) begin bad++; $display("FAIL dbl_word%0d got=%h exp=%h", i, gotq[i], expq[i]); end
    end
    gotq.delete(); expq.delete();
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] head;
    o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      send(32, $urandom, 1'b0);
      total++;
      if (i_ready !== ((expq.size() - gotq.size()) <= int'(DEPTH) - 2)) begin
        bad++; $display("FAIL bp_ready%0d got=%b buffered=%0d", k, i_ready, expq.size() - gotq.size());
      end
    end
    head = expq[0][OUT_W-1:0];
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (o_valid !== 1'b1 || o_data !== head) begin bad++; $display("FAIL bp_hold got=%b/%h exp=1/%h", o_valid, o_data, head); end
    end
    o_ready = 1'b1;
    send(32, $urandom, 1'b0);
    drain();
    total++;
    if (gotq.size() != expq.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", gotq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      total++;
      if (gotq[i] !== expq[i]) begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", i, gotq[i], expq[i]); end
    end
    gotq.delete(); expq.delete();
  endtask

  task automatic test_random();
    auto_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      o_ready = ($urandom_range(0, 3) != 0);
      send(int'($urandom_range(0, 40)), $urandom, ($urandom_range(0, 7) == 0));
      total++;
      if (rest !== model_rest()) begin bad++; $display("FAIL rnd_rest%0d got=%0d exp=%0d", k, rest, model_rest()); end
      total++;
      if (err !== err_m) begin bad++; $display("FAIL rnd_err%0d got=%b exp=%b", k, err, err_m); end
    end
    send(0, 32'h0, 1'b1);
    auto_rdy = 1'b0;
    drain();
    total++;
    if (gotq.size() != expq.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", gotq.size(), expq.size()); end
    for (int i = 0; i < expq.size() && i < gotq.size(); i++) begin
      total++;
      if (gotq[i] !== expq[i]) begin bad++; $display("FAIL rnd_word%0d got=%h exp=%h", i, gotq[i], expq[i]); end
    end
    gotq.delete(); expq.delete();
  endtask

  task automatic test_reset_mid();
    o_ready = 1'b0;
    send(40, 32'hFFFF_FFFF, 1'b0);
    send(32, $urandom, 1'b0);
    send(32, $urandom, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL rm_err_set got=%b exp=1", err); end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rm_o_valid got=%b exp=0", o_valid); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rm_err got=%b exp=0", err); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL rm_o_data got=%h exp=0", o_data); end
    @(posedge clk);
    #1 rst = 1'b0;
    mbits.delete(); expq.delete(); gotq.delete();
    err_m = 1'b0;
    o_ready = 1'b1;
    send(8, 32'h0000_00A5, 1'b1);
    drain();
    total++;
    if (gotq.size() != 1 || gotq[0] !== 33'h1_0000_00A5) begin
      bad++; $display("FAIL rm_word n=%0d got=%h exp=1000000a5", gotq.size(), (gotq.size() > 0) ? gotq[0] : 'x);
    end
    gotq.delete(); expq.delete();
  endtask

  initial begin
    test_reset();
    test_nibbles();
    test_mixed();
    test_flush();
    test_double_write();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
